// File: rtl/pwm_bank_pkg.sv
// Register map and control-word layout shared by the pwm_bank_tt slice.
// The PWM_BANK_READBACK_EN build uses ctrl_encode for register readback.
package pwm_bank_pkg;
  localparam logic [2:0] ADDR_CTRL      = 3'd7;
  localparam logic       MODE_EDGE      = 1'b0;
  localparam logic       MODE_CENTRE    = 1'b1;
  localparam int         CTRL_MODE_BIT  = 0;
  localparam int         CTRL_RUN_BIT   = 1;
  localparam int         CTRL_PRESC_LSB = 4;
  localparam int         PRESC_FIELD_W  = 3;

  typedef struct packed {
    logic [PRESC_FIELD_W-1:0] presc;
    logic                     run;
    logic                     mode;
  } ctrl_t;

  // Prescale bits above presc_w are dropped so they read back as zero.
  function automatic ctrl_t ctrl_decode(logic [7:0] d, int presc_w);
    ctrl_t c;
    c.mode = d[CTRL_MODE_BIT];
    c.run  = d[CTRL_RUN_BIT];
    for (int b = 0; b < PRESC_FIELD_W; b++)
      c.presc[b] = (b < presc_w) ? d[CTRL_PRESC_LSB+b] : 1'b0;
    return c;
  endfunction

  function automatic logic [7:0] ctrl_encode(ctrl_t c);
    logic [7:0] d;
    d = '0;
    d[CTRL_MODE_BIT] = c.mode;
    d[CTRL_RUN_BIT]  = c.run;
    d[CTRL_PRESC_LSB +: PRESC_FIELD_W] = c.presc;
    return d;
  endfunction
endpackage

// File: rtl/pwm_bank_if.sv
// Tile pin bundle for pwm_bank_tt: config strobe/address, data in, PWM and readback out.
interface pwm_bank_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/pwm_bank_counter.sv
// Prescaler plus edge/centre-aligned period counter; flags the period boundary
// (a tick while cnt==0), where the parent reloads duty and the new mode latches.
module pwm_bank_counter
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               run,
  input  logic               mode,
  input  logic [PRESC_W-1:0] presc,
  output logic [CNT_W-1:0]   cnt,
  output logic               bnd
);
  localparam int               DIV_W   = (1 << PRESC_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DIV_W-1:0] div, div_mask;
  logic             tick, dir_dn, mode_act;

  // Tick fires when the low p bits of the free-running divider are all ones.
  always_comb begin
    div_mask = '0;
    for (int b = 0; b < DIV_W; b++) div_mask[b] = (b < int'(presc));
  end

  assign tick = run && ((div & div_mask) == div_mask);
  assign bnd  = tick && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      cnt      <= '0;
      dir_dn   <= 1'b0;
      mode_act <= MODE_EDGE;
    end else if (ena) begin
      if (!run) begin
        div    <= '0;
        cnt    <= '0;
        dir_dn <= 1'b0;
      end else begin
        div <= div + 1'b1;
        if (tick) begin
          if (cnt == '0) begin
            // Period start: every mode leaves 0 upwards, and a pending mode change lands here.
            cnt      <= CNT_W'(1);
            dir_dn   <= 1'b0;
            mode_act <= mode;
          end else if (mode_act == MODE_EDGE) begin
            cnt <= cnt + 1'b1;
          end else if (!dir_dn) begin
            if (cnt == CNT_MAX) begin
              cnt    <= CNT_MAX - 1'b1;
              dir_dn <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/pwm_bank_tt.sv
// Multi-channel PWM tile: shadowed duty registers, ctrl register and compare outputs.
// Define PWM_BANK_READBACK_EN to drive register readback onto uio_out/uio_oe.
module pwm_bank_tt
  import pwm_bank_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  pwm_bank_if.slave       pins
);
  logic [N_CH-1:0][CNT_W-1:0] duty_sh, duty_sh_nx, duty_act;
  ctrl_t                      ctrl;
  logic                       stb_q, wr, bnd;
  logic [2:0]                 addr;
  logic [CNT_W-1:0]           cnt;
  logic [N_CH-1:0]            pwm_q;
  logic                       unused_pins;

  assign addr        = pins.ui_in[2:0];
  assign wr          = ena && pins.ui_in[7] && !stb_q;
  assign unused_pins = ^{pins.ui_in, pins.uio_in};

  // Shadow with this cycle's write applied, so a boundary in the same cycle loads it.
  always_comb begin
    duty_sh_nx = duty_sh;
    for (int i = 0; i < N_CH; i++)
      if (wr && addr == 3'(i) && addr != ADDR_CTRL) duty_sh_nx[i] = pins.uio_in[CNT_W-1:0];
  end

  pwm_bank_counter #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .run   (ctrl.run),
    .mode  (ctrl.mode),
    .presc (ctrl.presc[PRESC_W-1:0]),
    .cnt   (cnt),
    .bnd   (bnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q    <= 1'b0;
      ctrl     <= '0;
      duty_sh  <= '0;
      duty_act <= '0;
      pwm_q    <= '0;
    end else if (ena) begin
      stb_q   <= pins.ui_in[7];
      duty_sh <= duty_sh_nx;
      if (wr && addr == ADDR_CTRL) ctrl <= ctrl_decode(pins.uio_in, PRESC_W);
      // Stopped: active follows shadow so the first period after run uses fresh values.
      if (!ctrl.run || bnd) duty_act <= duty_sh_nx;
      for (int i = 0; i < N_CH; i++)
        pwm_q[i] <= ctrl.run && (cnt < duty_act[i]);
    end
  end

  assign pins.uo_out = 8'(pwm_q);

`ifdef PWM_BANK_READBACK_EN
  logic [7:0] rd_data, rb_q, oe_q;

  always_comb begin
    rd_data = '0;
    if (addr == ADDR_CTRL) rd_data = ctrl_encode(ctrl);
    else
      for (int i = 0; i < N_CH; i++)
        if (addr == 3'(i)) rd_data[CNT_W-1:0] = duty_sh[i];
  end

  // An asserted write strobe wins over read select and keeps the bus released.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_q <= '0;
      oe_q <= '0;
    end else if (ena) begin
      if (pins.ui_in[6] && !pins.ui_in[7]) begin
        rb_q <= rd_data;
        oe_q <= 8'hFF;
      end else begin
        rb_q <= '0;
        oe_q <= '0;
      end
    end
  end

  assign pins.uio_out = rb_q;
  assign pins.uio_oe  = oe_q;
`else
  assign pins.uio_out = '0;
  assign pins.uio_oe  = '0;
`endif
endmodule

// File: tb/tb_pwm_bank_tt.sv
// Scoreboard bench for pwm_bank_tt: a period/position reference model predicts every
// cycle's pins; a monitor compares them at negedge. Directed windows check duty counts.
module tb_pwm_bank_tt;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 3;
  localparam int MAXV    = (1 << CNT_W) - 1;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] rb;
    logic [7:0] oe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  pwm_bank_if ifc ();

  pwm_bank_tt #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .pins (ifc)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current period plus the period's mode.
  int   m_shadow[8], m_active[8];
  bit   m_mode, m_run, m_prev, m_pmode;
  int   m_p, m_k, m_pos;
  logic [7:0] m_uo, m_rb, m_oe;

  function automatic int cnt_of(int pos, bit centre);
    if (!centre || pos <= MAXV) return pos;
    return 2 * MAXV - pos;
  endfunction

  task automatic model_step();
    bit wr, tick, bnd;
    int a, len;
    logic [7:0] ui, nuo, nrb, noe;
    exp_t e;
    ui = ifc.ui_in;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      m_mode = 0; m_run = 0; m_p = 0; m_prev = 0; m_k = 0; m_pos = 0; m_pmode = 0;
      m_uo = 0; m_rb = 0; m_oe = 0;
    end else if (ena) begin
      a  = int'(ui[2:0]);
      wr = ui[7] && !m_prev;
      nuo = 0;
      for (int i = 0; i < N_CH; i++)
        if (m_run && cnt_of(m_pos, m_pmode) < m_active[i]) nuo[i] = 1'b1;
      nrb = 0; noe = 0;
`ifdef PWM_BANK_READBACK_EN
      if (ui[6] && !ui[7]) begin
        noe = 8'hFF;
        if (a == 7) nrb = 8'(m_mode) | (8'(m_run) << 1) | 8'(m_p << 4);
        else if (a < N_CH) nrb = 8'(m_shadow[a]);
      end
`endif
      bnd = 0;
      if (!m_run) begin
        m_k = 0; m_pos = 0;
      end else begin
        tick = (m_k % (1 << m_p)) == (1 << m_p) - 1;
        m_k++;
        if (tick) begin
          if (m_pos == 0) begin
            bnd = 1; m_pmode = m_mode; m_pos = 1;
          end else begin
            len = m_pmode ? 2 * MAXV : MAXV + 1;
            m_pos = (m_pos + 1) % len;
          end
        end
      end
      if (wr && a < N_CH && a != 7) m_shadow[a] = int'(ifc.uio_in) & MAXV;
      if (!m_run || bnd)
        for (int i = 0; i < N_CH; i++) m_active[i] = m_shadow[i];
      if (wr && a == 7) begin
        m_mode = ifc.uio_in[0];
        m_run  = ifc.uio_in[1];
        m_p    = int'(ifc.uio_in[6:4]) & ((1 << PRESC_W) - 1);
      end
      m_prev = ui[7];
      m_uo = nuo; m_rb = nrb; m_oe = noe;
    end
    e.uo = m_uo; e.rb = m_rb; e.oe = m_oe;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expected entry per clock; pins are sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (ifc.uo_out !== e.uo || ifc.uio_out !== e.rb || ifc.uio_oe !== e.oe) begin
          failures++;
          $display("FAIL pins t=%0t uo_out=%h exp=%h uio_out=%h exp=%h uio_oe=%h exp=%h",
                   $time, ifc.uo_out, e.uo, ifc.uio_out, e.rb, ifc.uio_oe, e.oe);
        end
      end
    end
  end

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(logic [2:0] a, logic [7:0] d);
    ifc.ui_in = {5'b10000, a};
    ifc.uio_in = d;
    @(negedge clk);
    ifc.ui_in = 8'h00;
    @(negedge clk);
  endtask

  task automatic count_high(int ch, int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (ifc.uo_out[ch]) hi++;
    end
  endtask

  initial begin
    int hi;
    logic [7:0] ui;
    ifc.ui_in = 8'h00;
    ifc.uio_in = 8'h00;
    cyc(3);
    check("reset_uo", int'(ifc.uo_out), 0);
    check("reset_oe", int'(ifc.uio_oe), 0);
    rst = 1'b0;
    cyc(2);

    // Edge mode, p=0: duty d is high exactly d cycles in any 256-cycle window.
    wr_reg(3'd0, 8'd64);
    wr_reg(3'd1, 8'd192);
    wr_reg(3'd7, 8'h02);
    cyc(300);
    count_high(0, 256, hi); check("edge_ch0_64", hi, 64);
    count_high(1, 256, hi); check("edge_ch1_192", hi, 192);

    // Centre mode: 0 and MAX visited once, 1..99 twice -> 199 high of 510.
    wr_reg(3'd7, 8'h03);
    wr_reg(3'd0, 8'd100);
    cyc(1100);
    count_high(0, 510, hi); check("centre_ch0_100", hi, 199);

    // Mid-period duty change in edge mode.
    wr_reg(3'd7, 8'h02);
    wr_reg(3'd0, 8'd64);
    cyc(600);
    wr_reg(3'd0, 8'd128);
    cyc(600);
    count_high(0, 256, hi); check("edge_ch0_128", hi, 128);

    // Held strobe: only the first strobe cycle's data is captured.
    for (int i = 0; i < 10; i++) begin
      ifc.ui_in = 8'h80;
      ifc.uio_in = 8'(10 + i * 7);
      @(negedge clk);
    end
    ifc.ui_in = 8'h00;
    cyc(600);
    count_high(0, 256, hi); check("held_strobe_one_write", hi, 10);

    // Prescale p=2, duty 1: 4-clock pulse per 1024 clocks; then freeze with ena low.
    wr_reg(3'd7, 8'h00);
    wr_reg(3'd0, 8'd1);
    wr_reg(3'd7, 8'h22);
    cyc(40);
    count_high(0, 1024, hi); check("presc_p2_pulse", hi, 4);
    ena = 1'b0;
    cyc(50);
    ena = 1'b1;
    cyc(1100);

    // Reset mid-period with run=1.
    wr_reg(3'd7, 8'h02);
    cyc(100);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_uo", int'(ifc.uo_out), 0);
    rst = 1'b0;
`ifdef PWM_BANK_READBACK_EN
    ifc.ui_in = 8'h40;
    cyc(1);
    check("rb_addr0_oe", int'(ifc.uio_oe), 255);
    check("rb_addr0_data", int'(ifc.uio_out), 0);
    ifc.ui_in = 8'h47;
    cyc(1);
    check("rb_ctrl_after_rst", int'(ifc.uio_out), 0);
    ifc.ui_in = 8'h00;
`endif
    cyc(300);
    check("rst_stays_stopped", int'(ifc.uo_out), 0);

    // Randomized traffic: strobes, reads, ena gaps and occasional reset.
    for (int c = 0; c < 5000; c++) begin
      ena = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 599) == 0);
      ui = 8'h00;
      if ($urandom_range(0, 7) == 0) ui[7] = 1'b1;
      if ($urandom_range(0, 3) == 0) ui[6] = 1'b1;
      ui[2:0] = 3'($urandom_range(0, 7));
      ifc.ui_in = ui;
      ifc.uio_in = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    ena = 1'b1;
    ifc.ui_in = 8'h00;
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
